// File: rtl/apb_pkg.sv
// Shared APB types and constants for the register-file responder.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package apb_pkg;

  localparam int APB_AW       = 32;
  localparam int APB_DW       = 32;
  localparam int APB_WAIT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_ACCESS
  } apb_state_e;

  // Transfer error: misaligned, beyond the register file, or a write to a read-only slot.
  // Only registers 0..31 can be read-only; the mask has one bit per register.
  function automatic logic apb_decode_err(input logic [APB_AW-1:0] addr,
                                          input logic              write,
                                          input int unsigned       num_regs,
                                          input logic [31:0]       ro_mask);
    logic misaligned;
    logic out_of_range;
    logic read_only;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr >= 32'(num_regs * 4));
    read_only    = write && (addr[APB_AW-1:7] == '0) && ro_mask[addr[6:2]];
    return misaligned || out_of_range || read_only;
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester and the register-file responder.
// Latency: n/a (wires only).
// Backpressure: the responder stretches transfers by holding PREADY low.
interface apb_slave_regfile_if;
  import apb_pkg::*;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_AW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_regbank.sv
// Register array: one write port with read-only filtering, one combinational read port.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none, every write request is accepted (read-only slots silently keep their value).
module apb_regbank
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] RO_MASK  = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_we,
  input  logic [$clog2(NUM_REGS)-1:0] i_widx,
  input  logic [APB_DW-1:0]           i_wdata,
  input  logic [$clog2(NUM_REGS)-1:0] i_ridx,
  output logic [APB_DW-1:0]           o_rdata,
  output logic [APB_DW-1:0]           o_reg0_q
);

  logic [NUM_REGS-1:0][APB_DW-1:0] r_regs;
  logic                            w_ro;

  // Only indices below 32 have a mask bit; higher registers are always writable.
  assign w_ro = (32'(i_widx) < 32'd32) && RO_MASK[5'(i_widx)];

  // Register storage: cleared on reset, written when enabled and not read-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
    end else if (i_we && !w_ro) begin
      r_regs[i_widx] <= i_wdata;
    end
  end

  assign o_rdata  = r_regs[i_ridx];
  assign o_reg0_q = r_regs[0];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB responder with built-in register file, WAIT_CYCLES wait states and PSLVERR reporting.
// Latency: PREADY rises WAIT_CYCLES+1 cycles after the setup cycle; a transfer takes WAIT_CYCLES+2 cycles.
// Backpressure: PREADY held low for WAIT_CYCLES access cycles; dropping PSEL/PENABLE mid-wait aborts the transfer.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] RO_MASK     = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  apb_slave_regfile_if.slave  apb,
  output logic [APB_DW-1:0]   reg0_q
);

  localparam int IW = $clog2(NUM_REGS);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic [APB_AW-1:0] r_addr;
  logic [APB_DW-1:0] r_wdata;
  logic              r_write;
  logic [3:0]        r_cnt;
  logic              r_pready;
  logic              r_pslverr;
  logic [APB_DW-1:0] r_prdata;

  logic              w_start;
  logic              w_can_start;
  logic              w_cont;
  logic              w_wait_done;
  logic [APB_AW-1:0] w_addr;
  logic              w_write;
  logic              w_err;
  logic              w_complete;
  logic              w_we;
  logic [IW-1:0]     w_widx;
  logic [IW-1:0]     w_ridx;
  logic [APB_DW-1:0] w_rdata;
  logic [APB_DW-1:0] w_rdata_fwd;

  assign w_start     = apb.PSEL && !apb.PENABLE;
  assign w_can_start = ((r_state == ST_IDLE) || (r_state == ST_ACCESS)) && w_start;
  assign w_cont      = apb.PSEL && apb.PENABLE;
  // The wait that ends this cycle is the last one once count+1 reaches WAIT_CYCLES.
  assign w_wait_done = ({1'b0, r_cnt} + 5'd1) >= 5'(WAIT_CYCLES);

  // Next-state decode; SETUP/WAIT abort to IDLE when the requester lets go of the bus.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_SETUP;
      end
      ST_SETUP, ST_WAIT: begin
        if (!w_cont)          w_next = ST_IDLE;
        else if (w_wait_done) w_next = ST_ACCESS;
        else                  w_next = ST_WAIT;
      end
      ST_ACCESS: begin
        if (w_start) w_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_SETUP;
        else         w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // With zero wait states the response is decided in the setup cycle itself, so decode
  // straight from the bus then; otherwise always from the latched copy.
  assign w_addr     = w_can_start ? apb.PADDR  : r_addr;
  assign w_write    = w_can_start ? apb.PWRITE : r_write;
  assign w_err      = apb_decode_err(w_addr, w_write, NUM_REGS, RO_MASK);
  assign w_ridx     = w_addr[IW+1:2];
  assign w_complete = (w_next == ST_ACCESS);

  // The write commits at the edge that closes the PREADY cycle.
  assign w_we   = (r_state == ST_ACCESS) && r_write &&
                  !apb_decode_err(r_addr, 1'b1, NUM_REGS, RO_MASK);
  assign w_widx = r_addr[IW+1:2];

  // A read decided in the same cycle as a committing write must see the new value.
  assign w_rdata_fwd = (w_we && (w_widx == w_ridx)) ? r_wdata : w_rdata;

  // State register and request latch; the wait counter restarts on every new transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_can_start) begin
        r_addr  <= apb.PADDR;
        r_wdata <= apb.PWDATA;
        r_write <= apb.PWRITE;
        r_cnt   <= '0;
      end else if (((r_state == ST_SETUP) || (r_state == ST_WAIT)) &&
                   (r_cnt != 4'(WAIT_CYCLES))) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Registered response; data and error are non-zero only in the PREADY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= w_complete;
      r_pslverr <= w_complete && w_err;
      r_prdata  <= (w_complete && !w_write && !w_err) ? w_rdata_fwd : '0;
    end
  end

  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;
  assign apb.PRDATA  = r_prdata;

  apb_regbank #(
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK)
  ) u_regbank (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_widx   (w_widx),
    .i_wdata  (r_wdata),
    .i_ridx   (w_ridx),
    .o_rdata  (w_rdata),
    .o_reg0_q (reg0_q)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile across three configurations (1, 3 and 0 wait states).
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [1:0]  dsel;
  int          exp_w;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic        pready_o, pslverr_o;
  logic [31:0] prdata_o, reg0_o;
  logic [31:0] reg0_a, reg0_b, reg0_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_regfile_if ifa ();
  apb_slave_regfile_if ifb ();
  apb_slave_regfile_if ifc ();

  assign ifa.PSEL = psel && (dsel == 2'd0);
  assign ifb.PSEL = psel && (dsel == 2'd1);
  assign ifc.PSEL = psel && (dsel == 2'd2);
  assign ifa.PENABLE = penable;  assign ifb.PENABLE = penable;  assign ifc.PENABLE = penable;
  assign ifa.PWRITE  = pwrite;   assign ifb.PWRITE  = pwrite;   assign ifc.PWRITE  = pwrite;
  assign ifa.PADDR   = paddr;    assign ifb.PADDR   = paddr;    assign ifc.PADDR   = paddr;
  assign ifa.PWDATA  = pwdata;   assign ifb.PWDATA  = pwdata;   assign ifc.PWDATA  = pwdata;

  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(1), .RO_MASK(32'h2)) dut_a (
    .clk(clk), .rst(rst), .apb(ifa.slave), .reg0_q(reg0_a));
  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(3), .RO_MASK(32'h0)) dut_b (
    .clk(clk), .rst(rst), .apb(ifb.slave), .reg0_q(reg0_b));
  apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(0), .RO_MASK(32'h0)) dut_c (
    .clk(clk), .rst(rst), .apb(ifc.slave), .reg0_q(reg0_c));

  // Route the selected responder to the common observation signals.
  always_comb begin
    pready_o  = ifa.PREADY;
    pslverr_o = ifa.PSLVERR;
    prdata_o  = ifa.PRDATA;
    reg0_o    = reg0_a;
    case (dsel)
      2'd1: begin pready_o = ifb.PREADY; pslverr_o = ifb.PSLVERR; prdata_o = ifb.PRDATA; reg0_o = reg0_b; end
      2'd2: begin pready_o = ifc.PREADY; pslverr_o = ifc.PSLVERR; prdata_o = ifc.PRDATA; reg0_o = reg0_c; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // One full transfer starting now (just after a rising edge). Returns at the cycle after PREADY.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err,
                      input logic [31:0] exp_rd, output int rdy_cyc);
    int k;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    k = 1;
    @(negedge clk);
    while (!pready_o && k < 20) begin
      @(posedge clk); #1;
      k++;
      @(negedge clk);
    end
    rdy_cyc = cyc;
    chk({tag, ".lat"}, k, exp_w + 1);
    chk({tag, ".err"}, pslverr_o, exp_err);
    if (!wr) chk({tag, ".rd"}, prdata_o, exp_rd);
    @(posedge clk); #1;
  endtask

  // Release the bus for n cycles; the response must be quiet in each of them.
  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle.rdy", pready_o, 1'b0);
      chk("idle.rd", prdata_o, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rc1, rc2;
    logic saw;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    dsel = 2'd0; exp_w = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", pready_o, 1'b0);
    chk("rst.err", pslverr_o, 1'b0);
    chk("rst.rd", prdata_o, 32'h0);
    chk("rst.reg0", reg0_o, 32'h0);
    chk("rst.b.reg0", reg0_b, 32'h0);
    chk("rst.c.rdy", ifc.PREADY, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Configuration A: one wait state, register 1 read-only.
    for (int i = 0; i < 16; i++) xfer("rst.read", 1'b0, 32'(i * 4), '0, 1'b0, 32'h0, rc1);
    idle(1);

    xfer("w08", 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, '0, rc1);
    xfer("r08", 1'b0, 32'h08, '0, 1'b0, 32'hDEADBEEF, rc1);
    chk("w08.reg0", reg0_o, 32'h0);

    xfer("w40", 1'b1, 32'h40, 32'hFFFFFFFF, 1'b1, '0, rc1);
    xfer("w05", 1'b1, 32'h05, 32'hFFFFFFFF, 1'b1, '0, rc1);
    xfer("w0e", 1'b1, 32'h0E, 32'hFFFFFFFF, 1'b1, '0, rc1);
    xfer("err.r00", 1'b0, 32'h00, '0, 1'b0, 32'h0, rc1);
    xfer("err.r08", 1'b0, 32'h08, '0, 1'b0, 32'hDEADBEEF, rc1);
    xfer("err.r0c", 1'b0, 32'h0C, '0, 1'b0, 32'h0, rc1);
    chk("err.reg0", reg0_o, 32'h0);

    xfer("ro.w04", 1'b1, 32'h04, 32'h1234, 1'b1, '0, rc1);
    xfer("ro.r04", 1'b0, 32'h04, '0, 1'b0, 32'h0, rc1);
    xfer("r40", 1'b0, 32'h40, '0, 1'b1, 32'h0, rc1);
    idle(1);

    xfer("b2b.w00", 1'b1, 32'h00, 32'h5, 1'b0, '0, rc1);
    xfer("b2b.r00", 1'b0, 32'h00, '0, 1'b0, 32'h5, rc2);
    chk("b2b.gap", rc2 - rc1, 32'd3);
    chk("b2b.reg0", reg0_o, 32'h5);
    idle(2);

    // Configuration B: three wait states, abort in the middle of a write.
    dsel = 2'd1; exp_w = 3;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pready_o) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort.rdy", saw, 1'b0);
    chk("abort.reg0", reg0_o, 32'h0);
    chk("abort.st", 32'(dut_b.r_state), 32'(ST_IDLE));
    xfer("abort.w00", 1'b1, 32'h00, 32'h77, 1'b0, '0, rc1);
    xfer("abort.r00", 1'b0, 32'h00, '0, 1'b0, 32'h77, rc2);
    chk("abort.gap", rc2 - rc1, 32'd5);
    chk("abort.reg0b", reg0_o, 32'h77);
    idle(2);

    // Configuration C: no wait states.
    dsel = 2'd2; exp_w = 0;
    xfer("w0.w10", 1'b1, 32'h10, 32'hCAFE, 1'b0, '0, rc1);
    xfer("w0.r10", 1'b0, 32'h10, '0, 1'b0, 32'hCAFE, rc2);
    chk("w0.gap", rc2 - rc1, 32'd2);
    xfer("w0.r44", 1'b0, 32'h44, '0, 1'b1, 32'h0, rc1);
    xfer("w0.r00", 1'b0, 32'h00, '0, 1'b0, 32'h0, rc1);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB responder with an integrated, parameterised register file, configurable wait states and error signalling. It is the completer end of the APB bus driven by `apb_master`. It sits directly on `PSEL`/`PENABLE`/`PWRITE`/`PADDR`/`PWDATA` and answers with `PRDATA`/`PREADY`/`PSLVERR`, with no separate register module. It replaces the slave+register pair in designs that need wait-state and error coverage.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers; power of two, 2..64.
- `WAIT_CYCLES`, 1: PREADY-low cycles inserted in every access phase; 0..15.
- `RO_MASK`, 32'h0: bit i set makes register i read-only. Writes to it are ignored and flagged with PSLVERR.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PSEL`  in  1  slave select.
- `PENABLE`  in  1  access-phase marker.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PADDR`  in  32  byte address.
- `PWDATA`  in  32  write data.
- `PRDATA`  out  32  read data; valid only while PREADY=1 on a read.
- `PREADY`  out  1  transfer-complete strobe.
- `PSLVERR`  out  1  error flag; valid only while PREADY=1.
- `reg0_q`  out  32  live value of register 0 (control output to the design).

## Operation
- FSM states:
  - IDLE → SETUP when PSEL=1 and PENABLE=0.
  - SETUP → WAIT if WAIT_CYCLES>0, else SETUP → ACCESS.
  - WAIT → ACCESS once the counter reaches WAIT_CYCLES.
  - ACCESS → SETUP if PSEL=1 and PENABLE=0 in the completion cycle (back-to-back); otherwise ACCESS → IDLE.
- In SETUP, latch PADDR, PWRITE and PWDATA. The latched copies are used for the whole transfer; later bus changes are ignored.
- Index = PADDR[log2(NUM_REGS)+1:2].
- Error conditions, decoded from the latched values:
  - PADDR[1:0] ≠ 0;
  - PADDR ≥ NUM_REGS*4;
  - write to a register whose RO_MASK bit is set.
- Write, no error: the register updates at the clock edge that ends the ACCESS cycle.
- Write, error: no register changes.
- Read, no error: PRDATA = register value.
- Read, error: PRDATA = 0.
- PSEL=0 while in WAIT or ACCESS-pending (abort): return to IDLE next cycle, no write, no PREADY pulse.
- PENABLE=0 while PSEL=1 during WAIT is a protocol violation and is treated as an abort.
- Reset values:
  - all registers 0, `reg0_q` = 0;
  - PRDATA = 0, PREADY = 0, PSLVERR = 0;
  - FSM in IDLE, wait counter 0.
- Reset asserted mid-transfer: the pending write is dropped, state returns to IDLE, and outputs take their reset values on the next edge.

## Timing
- Outputs are registered; no combinational path from inputs to PREADY/PRDATA/PSLVERR.
- Call the SETUP cycle T0, with PENABLE=1 from T1.
  - PREADY is low in cycles T1..T(WAIT_CYCLES).
  - PREADY is high in cycle T(WAIT_CYCLES+1) for exactly one cycle.
- Total transfer length: WAIT_CYCLES+2 cycles.
- PRDATA and PSLVERR are driven only in the PREADY=1 cycle; they are 0 in all other cycles.
- A read issued immediately after a write to the same register returns the new value (the write completes before the next SETUP).
- Throughput, back-to-back: one transfer every WAIT_CYCLES+2 cycles.
- The wait counter is 4 bits, saturates at WAIT_CYCLES, and clears on SETUP entry.

## Structure
- Shared package `apb_pkg`:
  - FSM state enum (IDLE, SETUP, WAIT, ACCESS);
  - APB data/address width constants (32);
  - `APB_WAIT_MAX` = 15.
- Natural sub-module `apb_regbank`: register array with a write port (we, idx, wdata), a combinational read port, the RO_MASK filter, and the `reg0_q` tap.
- FSM, address decode and error logic stay in the top level.

## Test plan
- Reset with WAIT_CYCLES=1 → PREADY=0, PRDATA=0, PSLVERR=0, `reg0_q`=0; a read of every register returns 0.
- Write 32'hDEADBEEF to 0x08, then read 0x08 → PREADY high exactly at T2; read returns DEADBEEF with PSLVERR=0; `reg0_q` unchanged.
- Write to 0x40 (NUM_REGS=16), then write to 0x05 → PSLVERR=1 in both completion cycles; the register file is unchanged.
- RO_MASK=32'h2; write 32'h1234 to 0x04 → PSLVERR=1; a read of 0x04 returns 0.
- WAIT_CYCLES=3; drop PSEL at T2 of a write to 0x00 → no PREADY pulse, `reg0_q` stays 0, FSM returns to IDLE; the next transfer completes normally.
- Back-to-back write 0x00=5 then read 0x00 with no idle cycle → two PREADY pulses 3 cycles apart (WAIT_CYCLES=1); the read returns 5.
